// File: rtl/adc_spi_sampler_if.sv
// Serial-ADC sampler bus: ADC pins (cs_n/sck/miso) plus the sample output
// handshake (sample/valid/busy). The sampler uses the master side; the ADC
// and the downstream consumer sit on the slave side.
interface adc_spi_sampler_if;
  logic       miso;
  logic       cs_n;
  logic       sck;
  logic [7:0] sample;
  logic       valid;
  logic       busy;

  modport master (
    input  miso,
    output cs_n,
    output sck,
    output sample,
    output valid,
    output busy
  );

  modport slave (
    output miso,
    input  cs_n,
    input  sck,
    input  sample,
    input  valid,
    input  busy
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodically runs one CS_N-low frame on an external serial
// ADC (MSB first), extracts the DATA_BITS result and publishes its top 8 bits
// on sample with a one-cycle valid strobe.
// Optional build macro ADC_AVG_EN: publish the truncated mean of every four
// results instead of every result.
module adc_spi_sampler #(
  parameter int CLK_DIV       = 25,
  parameter int FRAME_BITS    = 16,
  parameter int SKIP_BITS     = 2,
  parameter int DATA_BITS     = 12,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic               clk,
  input  logic               rst,
  adc_spi_sampler_if.master  bus
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int TMR_W = $clog2(2 * CLK_DIV + 1);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  // Skip bits fall off the top of the shift register, so after a full frame
  // the result MSB sits at the top and trailing frame bits sit below it.
  localparam int SH_W  = FRAME_BITS - SKIP_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_r;
  logic [PER_W-1:0]  period_r;
  logic              pending_r;
  logic [TMR_W-1:0]  tmr_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [SH_W-1:0]   shreg_r;
  logic              cs_n_r;
  logic              sck_r;
  logic [7:0]        sample_r;
  logic              valid_r;
  logic              busy_r;

  logic              wrap_s;
  logic              half_end_s;
  logic              quiet_end_s;
  logic              take_s;
  logic [7:0]        result_s;

`ifdef ADC_AVG_EN
  logic [9:0]        acc_r;
  logic [1:0]        avg_cnt_r;
  logic [9:0]        acc_sum_s;
  assign acc_sum_s = acc_r + {2'b00, result_s};
`endif

  assign wrap_s      = (period_r == PER_W'(SAMPLE_PERIOD - 1));
  assign half_end_s  = (tmr_r == TMR_W'(CLK_DIV - 1));
  assign quiet_end_s = (tmr_r == TMR_W'(2 * CLK_DIV - 1));
  // A pending request starts a frame from IDLE, or straight out of the DONE
  // quiet time so back-to-back frames are separated only by that quiet time.
  assign take_s      = pending_r &&
                       ((state_r == IDLE) || ((state_r == DONE) && quiet_end_s));
  assign result_s    = shreg_r[SH_W-1 -: 8];

  assign bus.cs_n    = cs_n_r;
  assign bus.sck     = sck_r;
  assign bus.sample  = sample_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;

  // Free-running conversion period timer, wraps every SAMPLE_PERIOD cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_r <= '0;
    end else if (wrap_s) begin
      period_r <= '0;
    end else begin
      period_r <= period_r + PER_W'(1);
    end
  end

  // Frame sequencer: pending flag, CS/SCK generation, shifting and publishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      tmr_r     <= '0;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      cs_n_r    <= 1'b1;
      sck_r     <= 1'b0;
      sample_r  <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
`ifdef ADC_AVG_EN
      acc_r     <= 10'd0;
      avg_cnt_r <= 2'd0;
`endif
    end else begin
      valid_r <= 1'b0;

      // A wrap while already pending is simply absorbed.
      if (wrap_s) begin
        pending_r <= 1'b1;
      end else if (take_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      case (state_r)
        IDLE: begin
          cs_n_r    <= 1'b1;
          sck_r     <= 1'b0;
          tmr_r     <= '0;
          bit_cnt_r <= '0;
          if (take_s) begin
            state_r <= CS_SETUP;
            cs_n_r  <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        CS_SETUP: begin
          if (half_end_s) begin
            // First SCK rise: the ADC has driven bit 0 since CS_N fell.
            tmr_r     <= '0;
            sck_r     <= 1'b1;
            shreg_r   <= {shreg_r[SH_W-2:0], bus.miso};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            state_r   <= SHIFT;
          end else begin
            tmr_r     <= tmr_r + TMR_W'(1);
          end
        end

        SHIFT: begin
          if (half_end_s) begin
            tmr_r <= '0;
            if (sck_r) begin
              sck_r <= 1'b0;
            end else if (bit_cnt_r == CNT_W'(FRAME_BITS)) begin
              // Final low half-period is over: close the frame and publish.
              state_r <= DONE;
              cs_n_r  <= 1'b1;
`ifdef ADC_AVG_EN
              if (avg_cnt_r == 2'd3) begin
                sample_r  <= acc_sum_s[9:2];
                valid_r   <= 1'b1;
                acc_r     <= 10'd0;
                avg_cnt_r <= 2'd0;
              end else begin
                acc_r     <= acc_sum_s;
                avg_cnt_r <= avg_cnt_r + 2'd1;
              end
`else
              sample_r <= result_s;
              valid_r  <= 1'b1;
`endif
            end else begin
              sck_r     <= 1'b1;
              shreg_r   <= {shreg_r[SH_W-2:0], bus.miso};
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end

        DONE: begin
          if (quiet_end_s) begin
            tmr_r     <= '0;
            bit_cnt_r <= '0;
            if (take_s) begin
              state_r <= CS_SETUP;
              cs_n_r  <= 1'b0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end

        default: begin
          state_r <= IDLE;
          cs_n_r  <= 1'b1;
          sck_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: a serial ADC model feeds queued conversion words,
// a negedge monitor measures frame timing, and a small model predicts sample.
`timescale 1ns/1ps
module tb_adc_spi_sampler;

  localparam int LAT = 2 * (1 + 2 * 16);

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  adc_spi_sampler_if bus_a ();
  adc_spi_sampler_if bus_b ();

  adc_spi_sampler #(
    .CLK_DIV(2), .FRAME_BITS(16), .SKIP_BITS(2), .DATA_BITS(12), .SAMPLE_PERIOD(200)
  ) u_dut (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );

  adc_spi_sampler #(
    .CLK_DIV(2), .FRAME_BITS(16), .SKIP_BITS(2), .DATA_BITS(12), .SAMPLE_PERIOD(10)
  ) u_fast (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] adc_q[$];

  // Monitor state (written only by the monitor process)
  int cyc = 0;
  int fall_cyc_a = 0, falls_a = 0, frames_a = 0, valids_a = 0;
  int rises_cur_a = 0, last_rises_a = 0, last_lat_a = 0;
  int last_period_a = 0, periods_a = 0, viol = 0;
  bit have_prev_a = 1'b0;
  logic [7:0] last_sample_a = 8'h00;
  logic pcs_a = 1'b1, psck_a = 1'b0;
  int frames_b = 0, valids_b = 0, rises_cur_b = 0, rise_cyc_b = 0;
  int gap_min_b = 9999, gap_max_b = 0, r_min_b = 9999, r_max_b = 0;
  bit have_rise_b = 1'b0;
  logic pcs_b = 1'b1, psck_b = 1'b0;

  // Reference model state (written only by the main sequence)
  int m_acc = 0, m_n = 0;
  logic [7:0] exp_held = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC model for the main instance: bit 0 appears at CS_N fall, later bits at SCK falls
  initial begin : adc_a
    logic pcs, psck;
    logic [15:0] fr;
    logic [11:0] w;
    int idx;
    bus_a.miso = 1'b0; pcs = 1'b1; psck = 1'b0; fr = 16'h0000; idx = 0;
    forever begin
      @(bus_a.cs_n or bus_a.sck);
      if (pcs && !bus_a.cs_n) begin
        w = (adc_q.size() > 0) ? adc_q.pop_front() : 12'h000;
        fr = {2'($urandom), w, 2'($urandom)};
        idx = 0;
        bus_a.miso = fr[15];
      end else if (psck && !bus_a.sck && !bus_a.cs_n) begin
        idx++;
        if (idx < 16) bus_a.miso = fr[15 - idx];
      end
      pcs = bus_a.cs_n; psck = bus_a.sck;
    end
  end

  // ADC model for the fast instance: always converts 12'hC3A
  initial begin : adc_b
    logic pcs, psck;
    logic [15:0] fr;
    int idx;
    bus_b.miso = 1'b0; pcs = 1'b1; psck = 1'b0; fr = {2'b10, 12'hC3A, 2'b01}; idx = 0;
    forever begin
      @(bus_b.cs_n or bus_b.sck);
      if (pcs && !bus_b.cs_n) begin
        idx = 0;
        bus_b.miso = fr[15];
      end else if (psck && !bus_b.sck && !bus_b.cs_n) begin
        idx++;
        if (idx < 16) bus_b.miso = fr[15 - idx];
      end
      pcs = bus_b.cs_n; psck = bus_b.sck;
    end
  end

  // Frame timing monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pcs_a && !bus_a.cs_n) begin
      if (have_prev_a) begin
        last_period_a = cyc - fall_cyc_a;
        periods_a++;
      end
      have_prev_a = 1'b1; fall_cyc_a = cyc; rises_cur_a = 0; falls_a++;
    end
    if (!psck_a && bus_a.sck && !bus_a.cs_n) rises_cur_a++;
    if (!pcs_a && bus_a.cs_n) begin frames_a++; last_rises_a = rises_cur_a; end
    if (bus_a.valid) begin
      valids_a++; last_sample_a = bus_a.sample; last_lat_a = cyc - fall_cyc_a;
    end
    if (bus_a.sck && bus_a.cs_n) viol++;
    if (rst_a) have_prev_a = 1'b0;
    pcs_a = bus_a.cs_n; psck_a = bus_a.sck;

    if (pcs_b && !bus_b.cs_n) begin
      if (have_rise_b) begin
        if (cyc - rise_cyc_b < gap_min_b) gap_min_b = cyc - rise_cyc_b;
        if (cyc - rise_cyc_b > gap_max_b) gap_max_b = cyc - rise_cyc_b;
      end
      rises_cur_b = 0;
    end
    if (!psck_b && bus_b.sck && !bus_b.cs_n) rises_cur_b++;
    if (!pcs_b && bus_b.cs_n && !rst_b) begin
      frames_b++; have_rise_b = 1'b1; rise_cyc_b = cyc;
      if (rises_cur_b < r_min_b) r_min_b = rises_cur_b;
      if (rises_cur_b > r_max_b) r_max_b = rises_cur_b;
    end
    if (bus_b.valid) valids_b++;
    if (bus_b.sck && bus_b.cs_n) viol++;
    pcs_b = bus_b.cs_n; psck_b = bus_b.sck;
  end

  // One conversion on the main instance, checked against the reference model
  task automatic conv(input logic [11:0] w, input string tag);
    int n0, v0, p0;
    bit pulse;
    logic [7:0] e;
    n0 = frames_a; v0 = valids_a; p0 = periods_a;
    adc_q.push_back(w);
`ifdef ADC_AVG_EN
    m_acc = m_acc + int'(w[11:4]);
    m_n = m_n + 1;
    if (m_n == 4) begin
      pulse = 1'b1; e = 8'(m_acc / 4); m_acc = 0; m_n = 0;
    end else begin
      pulse = 1'b0; e = 8'h00;
    end
`else
    pulse = 1'b1; e = w[11:4];
`endif
    if (pulse) exp_held = e;
    for (int i = 0; i < 2000 && frames_a == n0; i++) @(negedge clk);
    @(negedge clk);
    check({tag, "_frame"}, 32'(frames_a - n0), 32'd1);
    check({tag, "_pulses"}, 32'(valids_a - v0), 32'(pulse));
    check({tag, "_rises"}, 32'(last_rises_a), 32'd16);
    check({tag, "_held"}, 32'(bus_a.sample), 32'(exp_held));
    if (pulse) begin
      check({tag, "_sample"}, 32'(last_sample_a), 32'(e));
      check({tag, "_latency"}, 32'(last_lat_a), 32'(LAT));
    end
    if (periods_a != p0) check({tag, "_period"}, 32'(last_period_a), 32'd200);
  endtask

  initial begin
    int f0, v0, fb, vb;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus_a.cs_n), 32'd1);
    check("rst_sck", 32'(bus_a.sck), 32'd0);
    check("rst_sample", 32'(bus_a.sample), 32'h00);
    check("rst_valid", 32'(bus_a.valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    rst_a = 1'b0;

    // Known word, extremes, then free-running random words
    conv(12'h5A3, "t1");
    conv(12'hFFF, "t6_fff");
    conv(12'h000, "t6_000");
    for (int k = 0; k < 5; k++) conv(12'($urandom), "t2_rand");
    conv(12'h7E1, "pre_rst");

    // Reset at the 7th SCK rise of a frame
    f0 = falls_a;
    adc_q.push_back(12'hABC);
    for (int i = 0; i < 2000 && falls_a == f0; i++) @(negedge clk);
    for (int i = 0; i < 200 && rises_cur_a < 7; i++) @(negedge clk);
    check("t4_reach7", 32'(rises_cur_a), 32'd7);
    v0 = valids_a;
    rst_a = 1'b1;
    @(negedge clk);
    check("t4_cs_n", 32'(bus_a.cs_n), 32'd1);
    check("t4_sck", 32'(bus_a.sck), 32'd0);
    check("t4_sample", 32'(bus_a.sample), 32'h00);
    check("t4_busy", 32'(bus_a.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    m_acc = 0; m_n = 0; exp_held = 8'h00;
    repeat (60) @(negedge clk);
    check("t4_no_valid", 32'(valids_a - v0), 32'd0);

    // Averaging group (also the first frames after the mid-frame reset)
    conv({8'h40, 4'($urandom)}, "t5_a");
    conv({8'h41, 4'($urandom)}, "t5_b");
    conv({8'h42, 4'($urandom)}, "t5_c");
    conv({8'h44, 4'($urandom)}, "t5_d");

    // Short period: back-to-back frames on the fast instance
    rst_b = 1'b0;
    for (int i = 0; i < 3000 && frames_b < 5; i++) @(negedge clk);
    @(negedge clk);
    fb = frames_b; vb = valids_b;
    check("t3_frames", 32'(fb >= 5), 32'd1);
    check("t3_gap_min", 32'(gap_min_b), 32'd4);
    check("t3_gap_max", 32'(gap_max_b), 32'd4);
    check("t3_rises_min", 32'(r_min_b), 32'd16);
    check("t3_rises_max", 32'(r_max_b), 32'd16);
    check("t3_sample", 32'(bus_b.sample), 32'hC3);
`ifdef ADC_AVG_EN
    check("t3_valids", 32'(vb), 32'(fb / 4));
`else
    check("t3_valids", 32'(vb), 32'(fb));
`endif
    check("sck_idle_low", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
